// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the scalar write-back
// stage and the multicycle vector unit. Vector results are queued in a small
// in-order buffer. Scalar writes normally win. The buffer head forces a
// one-cycle pipeline stall in two cases: when it has been denied MAX_WAIT
// times in a row, or when it targets the same register as the current scalar
// write. Forcing the vector write out first keeps the older write ahead of the
// newer one.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   s_valid/s_rd/s_data  scalar write request (held by upstream while stalled)
//   v_valid/v_rd/v_data  vector result, accepted when v_ready is high
//   v_ready              registered, high while the buffer has a free entry
//   pipe_stall           combinational scalar-pipeline freeze
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   buf_count            current buffer occupancy
module wb_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int BUF_DEPTH = 2,
  parameter int MAX_WAIT  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  input  logic [ADDR_W-1:0]            s_rd,
  input  logic [DATA_W-1:0]            s_data,
  input  logic                         v_valid,
  input  logic [ADDR_W-1:0]            v_rd,
  input  logic [DATA_W-1:0]            v_data,
  output logic                         v_ready,
  output logic                         pipe_stall,
  output logic                         rf_we,
  output logic [ADDR_W-1:0]            rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  output logic [$clog2(BUF_DEPTH):0]   buf_count
);

  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(BUF_DEPTH);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  // Saturating increment of the starvation counter.
  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v == MAX_WAIT_C) ? v : v + 1'b1;
  endfunction

  logic [ADDR_W-1:0] mem_rd   [BUF_DEPTH];
  logic [DATA_W-1:0] mem_data [BUF_DEPTH];

  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              v_ready_q, v_ready_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic              nonempty, push, pop, grant_s, grant_v, stall;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    nonempty  = (count_q != '0);
    head_rd   = mem_rd[rptr_q];
    head_data = mem_data[rptr_q];
    // v_ready_q is only high when not full, so a full buffer never pushes
    // even if it pops this cycle.
    push      = v_valid && v_ready_q;
    stall     = nonempty && ((wait_q == MAX_WAIT_C) || (s_valid && (s_rd == head_rd)));
    grant_s   = s_valid && !stall;
    grant_v   = nonempty && !grant_s;
    pop       = grant_v;
  end

  always_comb begin
    wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    v_ready_d  = (count_d < DEPTH_C);
    // The head is denied only when the scalar side takes the port.
    wait_d     = (!nonempty || pop) ? '0 : sat_inc(wait_q);
    rf_we_d    = grant_s || grant_v;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_s) begin
      rf_waddr_d = s_rd;
      rf_wdata_d = s_data;
    end else if (grant_v) begin
      rf_waddr_d = head_rd;
      rf_wdata_d = head_data;
    end
  end

  // Control and output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      v_ready_q  <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      v_ready_q  <= v_ready_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Buffer storage stage: entries are qualified by count, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wptr_q]   <= v_rd;
      mem_data[wptr_q] <= v_data;
    end
  end

  assign v_ready    = v_ready_q;
  assign pipe_stall = stall;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign buf_count  = count_q;

endmodule
